skew_line: RTL and testbench

Parametrised, per-lane delay register bank for the systolic-array datapath. It generalises the plain 8-bit clearable register into CHANNELS lanes of WIDTH bits. Lane k is delayed by a lane-dependent number of enabled cycles, which produces the diagonal input skew that feeds the array edge, or, in deskew mode, realigns the array outputs. Each lane carries a valid bit alongside its data. Bubbles are forced to zero, and the block supports stall and flush.

---
 rtl/skew_line.sv | 62 ++++++
 tb/tb_skew_line.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/skew_line.sv
// Per-lane delay register bank: lane k is a chain of D(k) data+valid stages,
// giving diagonal input skew (DESKEW=0) or its mirror for output realignment.
module skew_line #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DESKEW   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        en,
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic [CHANNELS-1:0]         out_valid,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic                        busy
);

    logic [CHANNELS-1:0] lane_busy;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        localparam int DEPTH = (DESKEW != 0) ? (CHANNELS - gi) : (gi + 1);

        logic [WIDTH-1:0] data_q  [DEPTH];
        logic [WIDTH-1:0] data_d  [DEPTH];
        logic [DEPTH-1:0] valid_q;
        logic [DEPTH-1:0] valid_d;

        // Bubbles enter as zero data so downstream MACs accumulate nothing.
        always_comb begin
            valid_d    = valid_q;
            data_d     = data_q;
            valid_d[0] = in_valid[gi];
            data_d[0]  = in_valid[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
            end else if (en) begin
                valid_q <= valid_d;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= data_d[i];
                end
            end
        end

        assign out_data[gi*WIDTH +: WIDTH] = data_q[DEPTH-1];
        assign out_valid[gi]               = valid_q[DEPTH-1];
        assign lane_busy[gi]               = |valid_q;
    end

    assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_line.sv
// Directed bench for skew_line: a skew instance feeding a deskew instance,
// covering reset, skew timing, stall, clear, bubble zeroing and round trip.
module tb_skew_line;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        en;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  sk_valid;
    logic [31:0] sk_data;
    logic        sk_busy;
    logic [3:0]  dk_valid;
    logic [31:0] dk_data;
    logic        dk_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    skew_line #(.WIDTH(8), .CHANNELS(4), .DESKEW(0)) u_skew (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(sk_valid), .out_data(sk_data), .busy(sk_busy)
    );

    skew_line #(.WIDTH(8), .CHANNELS(4), .DESKEW(1)) u_deskew (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .in_valid(sk_valid), .in_data(sk_data),
        .out_valid(dk_valid), .out_data(dk_data), .busy(dk_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_skew(input string tag, input logic [3:0] v, input logic [31:0] d, input logic b);
        check({tag, "_valid"}, {28'd0, sk_valid}, {28'd0, v});
        check({tag, "_data"}, sk_data, d);
        check({tag, "_busy"}, {31'd0, sk_busy}, {31'd0, b});
        $display("%s: valid=%b data=%h busy=%b", tag, sk_valid, sk_data, sk_busy);
    endtask

    function automatic logic [31:0] vec(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b1;
        in_valid = 4'hF; in_data = 32'hFFFF_FFFF;

        // Reset dominates a presented valid sample
        tick(); expect_skew("rst0", 4'h0, 32'h0, 1'b0);
        tick(); expect_skew("rst1", 4'h0, 32'h0, 1'b0);
        rst = 1'b0; in_valid = 4'h0; in_data = 32'h0;
        tick(); expect_skew("rst_rel", 4'h0, 32'h0, 1'b0);

        // Skew: lane k exits after edge k
        in_valid = 4'hF; in_data = 32'h0403_0201;
        tick(); expect_skew("skew_e0", 4'b0001, 32'h0000_0001, 1'b1);
        in_valid = 4'h0; in_data = 32'h0;
        tick(); expect_skew("skew_e1", 4'b0010, 32'h0000_0200, 1'b1);
        tick(); expect_skew("skew_e2", 4'b0100, 32'h0003_0000, 1'b1);
        tick(); expect_skew("skew_e3", 4'b1000, 32'h0400_0000, 1'b1);
        tick(); expect_skew("skew_e4", 4'b0000, 32'h0000_0000, 1'b0);

        // Stall for 3 cycles after edge 1; inputs during stall are ignored
        in_valid = 4'hF; in_data = 32'h0403_0201;
        tick(); expect_skew("stall_e0", 4'b0001, 32'h0000_0001, 1'b1);
        in_valid = 4'h0; in_data = 32'h0;
        tick(); expect_skew("stall_e1", 4'b0010, 32'h0000_0200, 1'b1);
        en = 1'b0; in_valid = 4'hF; in_data = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_skew($sformatf("stall_hold%0d", i), 4'b0010, 32'h0000_0200, 1'b1);
        end
        en = 1'b1; in_valid = 4'h0; in_data = 32'h0;
        tick(); expect_skew("stall_e2", 4'b0100, 32'h0003_0000, 1'b1);
        tick(); expect_skew("stall_e3", 4'b1000, 32'h0400_0000, 1'b1);
        tick(); expect_skew("stall_e4", 4'b0000, 32'h0000_0000, 1'b0);

        // Clear mid-flight drops everything including the sample on that edge
        in_valid = 4'hF; in_data = 32'h0403_0201;
        tick(); expect_skew("clr_e0", 4'b0001, 32'h0000_0001, 1'b1);
        in_valid = 4'h0; in_data = 32'h0;
        tick(); expect_skew("clr_e1", 4'b0010, 32'h0000_0200, 1'b1);
        clear = 1'b1; in_valid = 4'hF; in_data = 32'hAAAA_AAAA;
        tick(); expect_skew("clr_e2", 4'b0000, 32'h0, 1'b0);
        check("clr_dk_busy", {31'd0, dk_busy}, 32'd0);
        clear = 1'b0; in_valid = 4'h0; in_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_skew($sformatf("clr_after%0d", i), 4'b0000, 32'h0, 1'b0);
        end

        // Bubbles inject zero data
        in_valid = 4'h0; in_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick(); expect_skew($sformatf("bubble%0d", i), 4'b0000, 32'h0, 1'b0);
        end

        // Deskew round trip: vector n at edge n emerges aligned after edge n+4
        clear = 1'b1; in_data = 32'h0;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 13; c++) begin
            logic [3:0]  ev;
            logic [31:0] ed;
            if (c < 8) begin
                in_valid = 4'hF; in_data = vec(c);
            end else begin
                in_valid = 4'h0; in_data = 32'h0;
            end
            tick();
            if (c >= 4 && c < 12) begin
                ev = 4'hF; ed = vec(c - 4);
            end else begin
                ev = 4'h0; ed = 32'h0;
            end
            check($sformatf("rt%0d_valid", c), {28'd0, dk_valid}, {28'd0, ev});
            check($sformatf("rt%0d_data", c), dk_data, ed);
            $display("rt%0d: valid=%b data=%h", c, dk_valid, dk_data);
        end
        check("rt_sk_busy", {31'd0, sk_busy}, 32'd0);
        check("rt_dk_busy", {31'd0, dk_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
